uart_word_feeder: RTL

Upstream stage of the UART transmitter: buffers 32-bit words from the data path in a small FIFO and serializes each word into four bytes for `uart_tx`. It paces the transmitter through its `enable`/`in_Byte`/`r_done` handshake, enforces the transmitter's post-frame recovery gap, and detects a stalled transmitter with a watchdog. Target is the Basys 3 at 100 MHz with `uart_tx` at 20 clocks per bit.

---
 rtl/uart_word_feeder_pkg.sv | 28 ++
 rtl/uart_word_feeder_if.sv | 25 ++
 rtl/uart_word_feeder_fifo.sv | 50 +++++
 rtl/uart_word_feeder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/uart_word_feeder_pkg.sv
// Shared constants for the UART transmit path: feeder state encoding and frame timing.
package uart_pkg;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_SEND = 2'd1;
  localparam logic [1:0] F_WAIT = 2'd2;
  localparam logic [1:0] F_GAP  = 2'd3;

  localparam int CLKS_PER_BIT      = 20;
  // start + 8 data + stop bits
  localparam int UART_FRAME_CYCLES = 10 * CLKS_PER_BIT;

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic msb_first);
    logic [1:0] lane;
    logic [7:0] r;
    lane = msb_first ? ~idx : idx;
    r = word[7:0];
    case (lane)
      2'd1:    r = word[15:8];
      2'd2:    r = word[23:16];
      2'd3:    r = word[31:24];
      default: r = word[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_word_feeder_if.sv
// Upstream word handshake plus uart_tx pacing signals and feeder status.
interface uart_word_feeder_if #(
  parameter int DEPTH = 4
);
  logic                   s_valid;
  logic                   s_ready;
  logic [31:0]            s_word;
  logic                   tx_enable;
  logic [7:0]             tx_byte;
  logic                   tx_done;
  logic                   word_done;
  logic                   busy;
  logic                   timeout_err;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output s_valid, s_word, tx_done,
    input  s_ready, tx_enable, tx_byte, word_done, busy, timeout_err, fifo_count
  );

  modport slave (
    input  s_valid, s_word, tx_done,
    output s_ready, tx_enable, tx_byte, word_done, busy, timeout_err, fifo_count
  );
endinterface

// File: rtl/uart_word_feeder_fifo.sv
// Show-ahead synchronous FIFO: rd_data presents the head word whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_word_feeder.sv
// Buffers 32-bit words and paces them into uart_tx one byte at a time,
// with a post-frame recovery gap and a per-byte stall watchdog.
//
// state  | meaning
// F_IDLE | waiting for a buffered word; pops the head when present
// F_SEND | tx_enable pulse, tx_byte updated to the selected byte
// F_WAIT | waiting for tx_done while the watchdog counts
// F_GAP  | recovery gap, then next byte or back to idle
module uart_word_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int MSB_FIRST      = 0,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clock,
  input logic               reset,
  uart_word_feeder_if.slave bus
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic             MSB      = (MSB_FIRST != 0);

  logic [1:0]       state;
  logic [31:0]      word_r;
  logic [1:0]       byte_idx;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             aborted;
  logic             tx_enable_r;
  logic [7:0]       tx_byte_r;
  logic             word_done_r;
  logic             timeout_err_r;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [31:0]      head;
  logic [CW-1:0]    count;

  assign pop             = (state == F_IDLE) && !fifo_empty;
  assign bus.s_ready     = !fifo_full && reset;
  assign bus.busy        = reset && (!fifo_empty || (state != F_IDLE));
  assign bus.fifo_count  = count;
  assign bus.tx_enable   = tx_enable_r;
  assign bus.tx_byte     = tx_byte_r;
  assign bus.word_done   = word_done_r;
  assign bus.timeout_err = timeout_err_r;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.s_valid && bus.s_ready),
    .wr_data (bus.s_word),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= F_IDLE;
      word_r        <= '0;
      byte_idx      <= '0;
      wd_cnt        <= '0;
      gap_cnt       <= '0;
      aborted       <= 1'b0;
      tx_enable_r   <= 1'b0;
      tx_byte_r     <= '0;
      word_done_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      tx_enable_r <= 1'b0;
      word_done_r <= 1'b0;
      case (state)
        F_IDLE: begin
          if (pop) begin
            word_r      <= head;
            byte_idx    <= 2'd0;
            aborted     <= 1'b0;
            tx_enable_r <= 1'b1;
            tx_byte_r   <= pick_byte(head, 2'd0, MSB);
            state       <= F_SEND;
          end
        end
        F_SEND: begin
          wd_cnt <= '0;
          state  <= F_WAIT;
        end
        F_WAIT: begin
          if (bus.tx_done) begin
            gap_cnt <= GAP_LOAD;
            state   <= F_GAP;
          end else if (wd_cnt == WD_LAST) begin
            // Stalled transmitter: drop the rest of this word and let the gap run out.
            timeout_err_r <= 1'b1;
            aborted       <= 1'b1;
            byte_idx      <= 2'd3;
            gap_cnt       <= GAP_LOAD;
            state         <= F_GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        F_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (byte_idx == 2'd3) begin
            word_done_r <= !aborted;
            state       <= F_IDLE;
          end else begin
            byte_idx    <= byte_idx + 2'd1;
            tx_enable_r <= 1'b1;
            tx_byte_r   <= pick_byte(word_r, byte_idx + 2'd1, MSB);
            state       <= F_SEND;
          end
        end
        default: state <= F_IDLE;
      endcase
    end
  end
endmodule
